// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sequencing states, default word width, channel codes.
// Imported by the receiver, its lrclk edge decoder and the transmitter.
package i2s_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } i2s_state_e;

    localparam int   I2S_WIDTH = 24;
    localparam logic CH_LEFT   = 1'b0;
    localparam logic CH_RIGHT  = 1'b1;

    // Channel carried by a given lrclk level.
    function automatic logic chan_of(input logic lr, input logic left_level);
        return (lr != left_level) ? CH_RIGHT : CH_LEFT;
    endfunction

endpackage

// File: rtl/i2s_receiver_if.sv
// Two-wire I2S serial bus (word select plus serial data), both launched on the
// rising edge of the bit clock by the master.
interface i2s_receiver_if;
    logic lrclk;
    logic sd;

    modport master (output lrclk, output sd);
    modport slave  (input lrclk, input sd);
endinterface

// File: rtl/i2s_lr_edge.sv
// Word-select history register with edge and channel decode.
// prev_lr has no reset branch: it tracks lrclk in every cycle, reset included.
module i2s_lr_edge
    import i2s_pkg::*;
#(
    parameter logic LEFT_LEVEL = 1'b0
) (
    input  logic sclk,
    input  logic lrclk,
    output logic lr_edge,
    output logic lr_ch
);

    logic prev_lr_q;
    logic prev_lr_d;

    always_comb begin
        prev_lr_d = lrclk;
    end

    always_ff @(posedge sclk) begin
        prev_lr_q <= prev_lr_d;
    end

    assign lr_edge = (lrclk != prev_lr_q);
    assign lr_ch   = chan_of(lrclk, LEFT_LEVEL);

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: fixed SLOT-bit channel slots, MSB one bit after each lrclk
// change, zero padding. left_in/right_in are expected to be quasi-static.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int   WIDTH      = I2S_WIDTH,
    parameter int   SLOT       = 32,
    parameter logic LEFT_LEVEL = 1'b0
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] left_in,
    input  logic [WIDTH-1:0] right_in,
    i2s_receiver_if.master   bus
);

    localparam int FRAME = 2 * SLOT;
    localparam int PW    = $clog2(FRAME);

    logic [PW-1:0]    pos_q, pos_d;
    logic             lrclk_q, lrclk_d;
    logic             sd_q, sd_d;
    logic [PW-1:0]    dly;
    logic [PW-1:0]    idx;
    logic             dly_right;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] word_shifted;

    always_comb begin
        pos_d   = (pos_q == PW'(FRAME - 1)) ? '0 : pos_q + 1'b1;
        lrclk_d = (pos_d < PW'(SLOT)) ? LEFT_LEVEL : ~LEFT_LEVEL;

        // Data trails word select by one bit, so bit k of a slot belongs to
        // the position one step back (wrapping into the previous slot).
        dly          = (pos_d == '0) ? PW'(FRAME - 1) : pos_d - 1'b1;
        dly_right    = (dly >= PW'(SLOT));
        idx          = dly_right ? dly - PW'(SLOT) : dly;
        word         = dly_right ? right_in : left_in;
        word_shifted = word << idx;
        sd_d         = 1'b0;
        if (idx < PW'(WIDTH)) begin
            sd_d = word_shifted[WIDTH-1];
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            pos_q   <= '0;
            lrclk_q <= LEFT_LEVEL;
            sd_q    <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            lrclk_q <= lrclk_d;
            sd_q    <= sd_d;
        end
    end

    assign bus.lrclk = lrclk_q;
    assign bus.sd    = sd_q;

endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: captures WIDTH-bit MSB-first words after each lrclk edge and
// presents per-word and stereo-pair strobes.
//
// state | meaning
// IDLE  | waiting for an lrclk edge; sdin ignored (padding)
// RECV  | shifting WIDTH bits of the current channel word
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int   WIDTH      = I2S_WIDTH,
    parameter logic LEFT_LEVEL = 1'b0
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             lrclk,
    input  logic             sdin,
    output logic [WIDTH-1:0] data_out,
    output logic             data_ch,
    output logic             data_valid,
    output logic [WIDTH-1:0] left_data,
    output logic [WIDTH-1:0] right_data,
    output logic             frame_valid,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH);

    logic lr_edge;
    logic lr_ch;

    i2s_lr_edge #(.LEFT_LEVEL(LEFT_LEVEL)) u_lr_edge (
        .sclk    (sclk),
        .lrclk   (lrclk),
        .lr_edge (lr_edge),
        .lr_ch   (lr_ch)
    );

    i2s_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             ch_q, ch_d;
    logic             left_seen_q, left_seen_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_ch_q, data_ch_d;
    logic             data_valid_q, data_valid_d;
    logic [WIDTH-1:0] left_data_q, left_data_d;
    logic [WIDTH-1:0] right_data_q, right_data_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [WIDTH-1:0] shift_next;
    logic             start;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        ch_d          = ch_q;
        left_seen_d   = left_seen_q;
        data_out_d    = data_out_q;
        data_ch_d     = data_ch_q;
        left_data_d   = left_data_q;
        right_data_d  = right_data_q;
        data_valid_d  = 1'b0;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        shift_next    = {shift_q[WIDTH-2:0], sdin};
        start         = 1'b0;

        case (state_q)
            IDLE: begin
                start = lr_edge;
            end
            RECV: begin
                shift_d = shift_next;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    data_out_d   = shift_next;
                    data_ch_d    = ch_q;
                    data_valid_d = 1'b1;
                    if (ch_q == CH_LEFT) begin
                        left_data_d = shift_next;
                        left_seen_d = 1'b1;
                    end else begin
                        right_data_d = shift_next;
                        if (left_seen_q) begin
                            frame_valid_d = 1'b1;
                            left_seen_d   = 1'b0;
                        end
                    end
                    // A coincident edge is the normal back-to-back case.
                    start = lr_edge;
                end else if (lr_edge) begin
                    frame_err_d = 1'b1;
                    left_seen_d = 1'b0;
                    start       = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start) begin
            state_d = RECV;
            cnt_d   = CW'(WIDTH - 1);
            ch_d    = lr_ch;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            ch_q          <= CH_LEFT;
            left_seen_q   <= 1'b0;
            data_out_q    <= '0;
            data_ch_q     <= 1'b0;
            data_valid_q  <= 1'b0;
            left_data_q   <= '0;
            right_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            ch_q          <= ch_d;
            left_seen_q   <= left_seen_d;
            data_out_q    <= data_out_d;
            data_ch_q     <= data_ch_d;
            data_valid_q  <= data_valid_d;
            left_data_q   <= left_data_d;
            right_data_q  <= right_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_ch     = data_ch_q;
    assign data_valid  = data_valid_q;
    assign left_data   = left_data_q;
    assign right_data  = right_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: directed and random I2S traffic checked every cycle
// against a history-based word model, plus literal checks per scenario.
module tb_i2s_receiver;
    import i2s_pkg::*;

    localparam int   W   = 24;
    localparam logic LL  = 1'b0;
    localparam int   HN  = 4096;

    logic          sclk = 1'b0;
    logic          rst;
    logic          tx_rst;
    logic          loop_en;
    logic          tb_lr;
    logic          tb_sd;
    logic          dut_lrclk;
    logic          dut_sdin;
    logic [W-1:0]  data_out;
    logic          data_ch;
    logic          data_valid;
    logic [W-1:0]  left_data;
    logic [W-1:0]  right_data;
    logic          frame_valid;
    logic          frame_err;

    i2s_receiver_if bus ();

    i2s_transmitter #(.WIDTH(W), .SLOT(32), .LEFT_LEVEL(LL)) u_tx (
        .sclk     (sclk),
        .rst      (tx_rst),
        .left_in  (24'hC0FFEE),
        .right_in (24'hC0FFEE),
        .bus      (bus)
    );

    assign dut_lrclk = loop_en ? bus.lrclk : tb_lr;
    assign dut_sdin  = loop_en ? bus.sd    : tb_sd;

    i2s_receiver #(.WIDTH(W), .LEFT_LEVEL(LL)) dut (
        .sclk        (sclk),
        .rst         (rst),
        .lrclk       (dut_lrclk),
        .sdin        (dut_sdin),
        .data_out    (data_out),
        .data_ch     (data_ch),
        .data_valid  (data_valid),
        .left_data   (left_data),
        .right_data  (right_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 sclk = ~sclk;

    // Model: what the line carried at each rising edge, and what the outputs
    // must show after that edge. A word exists only between two rst-free
    // lrclk edges at least W apart; its bits are the W samples after the edge.
    bit          lr_h [0:HN-1];
    bit          sd_h [0:HN-1];
    int          cyc       = 0;
    int          last_edge = -1;
    int          last_rst  = -1;
    logic [W-1:0] m_dout  = '0;
    logic [W-1:0] m_left  = '0;
    logic [W-1:0] m_right = '0;
    logic        m_ch = 1'b0;
    logic        m_dv = 1'b0;
    logic        m_fv = 1'b0;
    logic        m_fe = 1'b0;
    logic        m_ls = 1'b0;

    always @(posedge sclk) begin
        int  t;
        int  d;
        int  w;
        bit  edge_t;
        t = cyc;
        if (t >= HN) begin
            $display("FAIL history_overflow: cycle %0d exceeds %0d", t, HN);
            $fatal(1);
        end
        lr_h[t] = dut_lrclk;
        sd_h[t] = dut_sdin;
        edge_t  = (rst == 1'b0) && (t > 0) && (lr_h[t] != lr_h[t-1]);
        m_dv = 1'b0;
        m_fv = 1'b0;
        m_fe = 1'b0;
        if (rst) begin
            m_dout = '0; m_left = '0; m_right = '0; m_ch = 1'b0; m_ls = 1'b0;
            last_rst = t;
        end else begin
            if (last_edge > last_rst) begin
                d = t - last_edge;
                if (d == W) begin
                    w = 0;
                    for (int i = 1; i <= W; i++) w = w * 2 + int'(sd_h[last_edge + i]);
                    m_dv   = 1'b1;
                    m_dout = W'(w);
                    m_ch   = (lr_h[last_edge] != LL);
                    if (!m_ch) begin
                        m_left = W'(w);
                        m_ls   = 1'b1;
                    end else begin
                        m_right = W'(w);
                        if (m_ls) begin
                            m_fv = 1'b1;
                            m_ls = 1'b0;
                        end
                    end
                end else if (d < W && edge_t) begin
                    m_fe = 1'b1;
                    m_ls = 1'b0;
                end
            end
            if (edge_t) last_edge = t;
        end
        cyc = cyc + 1;
    end

    int n_cmp = 0;
    int n_err = 0;
    int cnt_dv = 0;
    int cnt_fv = 0;
    int cnt_fe = 0;
    int cnt_fv_rdv = 0;
    bit dv_ch_q[$];
    logic carry = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_now();
        chk("data_valid", 32'(data_valid), 32'(m_dv));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("frame_err", 32'(frame_err), 32'(m_fe));
        chk("data_ch", 32'(data_ch), 32'(m_ch));
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("left_data", 32'(left_data), 32'(m_left));
        chk("right_data", 32'(right_data), 32'(m_right));
        if (data_valid === 1'b1) begin
            cnt_dv++;
            dv_ch_q.push_back(data_ch);
        end
        if (frame_valid === 1'b1) cnt_fv++;
        if (frame_valid === 1'b1 && data_valid === 1'b1 && data_ch === 1'b1) cnt_fv_rdv++;
        if (frame_err === 1'b1) cnt_fe++;
    endtask

    task automatic tick(input logic lr, input logic sd);
        @(negedge sclk);
        compare_now();
        tb_lr = lr;
        tb_sd = sd;
    endtask

    // pad_mode: 0 zeros, 1 ones, 2 random
    task automatic send_slot(input logic lvl, input logic [W-1:0] word, input int slot, input int pad_mode);
        logic sd;
        for (int k = 0; k < slot; k++) begin
            if (k == 0) sd = carry;
            else if (k <= W) sd = word[W-k];
            else if (pad_mode == 2) sd = ($urandom_range(0, 1) != 0);
            else sd = (pad_mode == 1);
            tick(lvl, sd);
        end
        if (slot == W) carry = word[0];
        else if (pad_mode == 2 || slot < W) carry = ($urandom_range(0, 1) != 0);
        else carry = (pad_mode == 1);
    endtask

    initial begin
        int   b_dv, b_fv, b_fe, b_rdv, b_q;
        int   slot;
        logic lvl;
        rst = 1'b1; tx_rst = 1'b1; loop_en = 1'b0; tb_lr = 1'b1; tb_sd = 1'b0;

        // Reset, then one standard 64-sclk frame
        repeat (4) tick(1'b1, 1'b0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        rst = 1'b0;
        repeat (6) tick(1'b1, 1'b0);
        b_dv = cnt_dv; b_fv = cnt_fv; b_fe = cnt_fe; b_rdv = cnt_fv_rdv; b_q = dv_ch_q.size();
        chk("s1_no_edge_after_release", 32'(cnt_dv + cnt_fe), 32'd0);
        send_slot(1'b0, 24'hA5A5A5, 32, 0);
        send_slot(1'b1, 24'h123456, 32, 0);
        repeat (4) tick(1'b1, 1'b0);
        chk("s1_dv_count", 32'(cnt_dv - b_dv), 32'd2);
        chk("s1_first_ch", 32'(dv_ch_q[b_q]), 32'd0);
        chk("s1_second_ch", 32'(dv_ch_q[b_q+1]), 32'd1);
        chk("s1_fv_count", 32'(cnt_fv - b_fv), 32'd1);
        chk("s1_fv_with_right_dv", 32'(cnt_fv_rdv - b_rdv), 32'd1);
        chk("s1_fe_count", 32'(cnt_fe - b_fe), 32'd0);
        chk("s1_left_data", 32'(left_data), 32'h00A5A5A5);
        chk("s1_right_data", 32'(right_data), 32'h00123456);

        // Early lrclk toggle 10 sclk into a left word
        b_dv = cnt_dv; b_fv = cnt_fv; b_fe = cnt_fe; b_q = dv_ch_q.size();
        send_slot(1'b0, W'($urandom), 10, 2);
        send_slot(1'b1, 24'h3C3C3C, 32, 0);
        repeat (4) tick(1'b1, 1'b0);
        chk("s2_fe_count", 32'(cnt_fe - b_fe), 32'd1);
        chk("s2_dv_count", 32'(cnt_dv - b_dv), 32'd1);
        chk("s2_dv_ch", 32'(dv_ch_q[b_q]), 32'd1);
        chk("s2_fv_count", 32'(cnt_fv - b_fv), 32'd0);
        chk("s2_right_data", 32'(right_data), 32'h003C3C3C);

        // Back-to-back 24-sclk slots: edge coincides with the last bit
        b_dv = cnt_dv; b_fv = cnt_fv; b_fe = cnt_fe;
        send_slot(1'b0, 24'h800001, 24, 0);
        send_slot(1'b1, 24'h7FFFFE, 24, 0);
        send_slot(1'b0, 24'h800001, 24, 0);
        send_slot(1'b1, 24'h7FFFFE, 24, 0);
        send_slot(1'b0, 24'h55AA55, 30, 0);
        repeat (4) tick(1'b0, 1'b0);
        chk("s3_dv_count", 32'(cnt_dv - b_dv), 32'd5);
        chk("s3_fe_count", 32'(cnt_fe - b_fe), 32'd0);
        chk("s3_fv_count", 32'(cnt_fv - b_fv), 32'd2);
        chk("s3_right_data", 32'(right_data), 32'h007FFFFE);
        chk("s3_left_data", 32'(left_data), 32'h0055AA55);

        // Reset in the middle of a word
        b_dv = cnt_dv; b_fv = cnt_fv; b_fe = cnt_fe;
        send_slot(1'b1, W'($urandom), 12, 2);
        rst = 1'b1;
        repeat (2) tick(1'b1, 1'b0);
        chk("s4_rst_data_out", 32'(data_out), 32'd0);
        chk("s4_rst_left", 32'(left_data), 32'd0);
        chk("s4_rst_right", 32'(right_data), 32'd0);
        chk("s4_rst_ch", 32'(data_ch), 32'd0);
        chk("s4_rst_strobes", 32'({data_valid, frame_valid, frame_err}), 32'd0);
        repeat (3) tick(1'b1, 1'b0);
        rst = 1'b0;
        repeat (8) tick(1'b1, 1'b0);
        chk("s4_no_strobe_dv", 32'(cnt_dv - b_dv), 32'd0);
        chk("s4_no_strobe_fe", 32'(cnt_fe - b_fe), 32'd0);
        chk("s4_no_strobe_fv", 32'(cnt_fv - b_fv), 32'd0);
        send_slot(1'b0, W'($urandom), 32, 2);
        send_slot(1'b1, W'($urandom), 32, 2);
        repeat (4) tick(1'b1, 1'b0);
        chk("s4_dv_count", 32'(cnt_dv - b_dv), 32'd2);
        chk("s4_fv_count", 32'(cnt_fv - b_fv), 32'd1);

        // 32-sclk slots padded with ones
        send_slot(1'b0, 24'h000000, 32, 1);
        send_slot(1'b1, 24'h000002, 32, 1);
        repeat (4) tick(1'b1, 1'b1);
        chk("s5_left_pad", 32'(left_data), 32'h00000000);
        chk("s5_right_pad", 32'(right_data), 32'h00000002);
        chk("s5_data_out_pad", 32'(data_out), 32'h00000002);

        // Random slot lengths, words and padding, occasional short slots
        lvl = ~tb_lr;
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 5) == 0) slot = $urandom_range(2, W - 1);
            else slot = $urandom_range(W, 40);
            send_slot(lvl, W'($urandom), slot, 2);
            lvl = ~lvl;
        end
        repeat (4) tick(tb_lr, 1'b0);

        // Loopback from the transmitter
        rst = 1'b1; tx_rst = 1'b1;
        repeat (3) tick(1'b0, 1'b0);
        loop_en = 1'b1;
        repeat (2) tick(1'b0, 1'b0);
        rst = 1'b0; tx_rst = 1'b0;
        b_dv = cnt_dv; b_fv = cnt_fv; b_fe = cnt_fe;
        repeat (200) tick(1'b0, 1'b0);
        chk("s7_left", 32'(left_data), 32'h00C0FFEE);
        chk("s7_right", 32'(right_data), 32'h00C0FFEE);
        chk("s7_data_out", 32'(data_out), 32'h00C0FFEE);
        chk("s7_fe_count", 32'(cnt_fe - b_fe), 32'd0);
        chk("s7_dv_at_least_4", 32'((cnt_dv - b_dv) >= 4), 32'd1);
        chk("s7_fv_at_least_1", 32'((cnt_fv - b_fv) >= 1), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
